div_seq: RTL
============

// Module: div_seq
// PURPOSE
//  Iterative restoring divider for the processor's multdiv unit, the inverse of the adder/multiplier datapath.
//  Produces one quotient bit per clock and returns quotient and remainder through a start/ready handshake.
//  Sits beside the ALU. The control unit stalls on busy and reads the result when result_rdy pulses.
// PARAMETERS
//  WIDTH  32  operand, quotient and remainder width in bits (must be >= 2)
// PORTS
//  clock         in   1      single clock; all state changes on its rising edge
//  reset_n       in   1      synchronous, active-low reset
//  start         in   1      request; sampled only while idle (busy=0)
//  signed_mode   in   1      1 = two's-complement divide, 0 = unsigned; sampled with start
//  dividend      in   WIDTH  numerator; sampled with start
//  divisor       in   WIDTH  denominator; sampled with start
//  busy          out  1      1 from the cycle after start is accepted until result_rdy has pulsed
//  result_rdy    out  1      one-cycle pulse: quotient, remainder and div_by_zero are valid
//  quotient      out  WIDTH  result quotient; held until the next accepted start
//  remainder     out  WIDTH  result remainder; held until the next accepted start
//  div_by_zero   out  1      set together with result_rdy when divisor==0; held like quotient
// BEHAVIOUR
//  Reset: when reset_n=0 at an edge, the next state is IDLE and busy, result_rdy, quotient, remainder and div_by_zero are all 0.
//   Reset overrides an operation in flight; any partial result is discarded.
//  FSM states: IDLE, RUN, FIX, DONE.
//   IDLE -> RUN: start=1 and divisor!=0. Latch |dividend| into the shift register and |divisor| into the divisor register,
//    where |x| is the magnitude if signed_mode=1 and the raw value otherwise. Clear partial remainder and count. Latch neg_q and neg_r.
//   IDLE -> DONE: start=1 and divisor==0. Load quotient=0, remainder=0, div_by_zero=1.
//   RUN: each edge does {r,q} <<= 1, trial t = r - dsr (WIDTH+1 bits).
//    If t is nonnegative, r=t and q[0]=1; otherwise q[0]=0. Then count++.
//   RUN -> FIX: after exactly WIDTH RUN edges (count==WIDTH-1 on the last edge).
//   FIX -> DONE: quotient = neg_q ? -q : q, remainder = neg_r ? -r : r, div_by_zero=0.
//   DONE -> IDLE: unconditionally after 1 cycle. result_rdy=1 only while in DONE.
//  Sign rules (signed_mode=1): neg_q = dividend[MSB]^divisor[MSB], neg_r = dividend[MSB].
//   Result truncates toward zero; the remainder takes the dividend's sign.
//  Overflow: signed MIN/-1 yields quotient=MIN and remainder=0 (magnitude 2^(WIDTH-1) wraps on negate). No flag is raised.
//  Latency: start accepted in cycle 0; result_rdy high in cycle WIDTH+2 (34 for WIDTH=32). For divide by zero, result_rdy is high in cycle 1.
//  busy = (state != IDLE). start asserted while busy is ignored and does not queue.
//  A start presented in the cycle right after DONE (state back in IDLE) is accepted normally.
//   Back-to-back throughput is therefore 1 op per WIDTH+3 cycles.
//  quotient, remainder and div_by_zero change only on entry to DONE (or reset). They are stable while RUN/FIX execute.
//  Operand inputs may change freely after the start cycle; only the latched copies are used.
//  No combinational path from any input to any output.
// TESTING
//  1 unsigned: start, dividend=100, divisor=7 -> result_rdy in cycle 34, quotient=14, remainder=2, div_by_zero=0; busy high cycles 1..34.
//  2 signed: dividend=-7, divisor=2 -> quotient=-3 (0xFFFFFFFD), remainder=-1. Also 7/-2 -> quotient=-3, remainder=1.
//  3 divide by zero: dividend=123, divisor=0 -> result_rdy in cycle 1, div_by_zero=1, quotient=0, remainder=0, busy back to 0 in cycle 2.
//  4 overflow and edges: signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
//    Unsigned 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0. Unsigned 5/9 -> quotient=0, remainder=5.
//  5 handshake: pulse start at cycle 0 (100/7), pulse start again at cycle 10 (50/5) -> second request ignored, result is 14 r 2.
//    A new start in the cycle after result_rdy is accepted.
//  6 reset mid-op: start 100/7, drive reset_n=0 at cycle 15 -> next cycle busy=0, result_rdy never pulses, all outputs 0.
//    A fresh start then completes with correct results.
//  Plus 10k random signed/unsigned pairs compared against the Verilog / and % operators with signed fixups.

Source files
------------

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq -- iterative restoring divider for the multdiv unit
//
// Produces one quotient bit per clock. A request is accepted while idle. The
// quotient, remainder and divide-by-zero flag appear together with a one-cycle
// result_rdy pulse, and they hold their values until the next accepted
// request. Signed operation uses a magnitude-and-sign scheme: divide the
// magnitudes, then negate the results as required in a dedicated FIX cycle.
//
// Ports
//   clock        in   1      rising-edge clock
//   reset_n      in   1      synchronous, active-low reset
//   start        in   1      request, sampled only while idle
//   signed_mode  in   1      1 = two's-complement divide, 0 = unsigned
//   dividend     in   WIDTH  numerator, sampled with start
//   divisor      in   WIDTH  denominator, sampled with start
//   busy         out  1      high while an operation is in flight (state != IDLE)
//   result_rdy   out  1      one-cycle pulse, results valid
//   quotient     out  WIDTH  result quotient (held)
//   remainder    out  WIDTH  result remainder (held)
//   div_by_zero  out  1      divisor was zero (held like quotient)
// -----------------------------------------------------------------------------
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             result_rdy,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_by_zero_q, div_by_zero_d;
    logic             busy_q, busy_d;
    logic             result_rdy_q, result_rdy_d;

    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Magnitudes of the incoming operands. The most negative value maps to
    // 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
    always_comb begin
        dividend_mag = (signed_mode && dividend[WIDTH-1]) ? -dividend : dividend;
        divisor_mag  = (signed_mode && divisor[WIDTH-1])  ? -divisor  : divisor;
    end

    // One restoring step. The partial remainder is always below the divisor,
    // so after shifting in the next dividend bit it fits in WIDTH+1 bits. The
    // MSB of the WIDTH+1-bit difference therefore acts as the sign of the
    // trial subtraction.
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dsr_q};
    end

    // Next-state and datapath logic. Result registers change only when
    // entering DONE, so they stay stable while RUN/FIX execute.
    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        quo_d         = quo_q;
        dsr_d         = dsr_q;
        count_d       = count_q;
        quo_neg_d     = quo_neg_q;
        rem_neg_d     = rem_neg_q;
        quotient_d    = quotient_q;
        remainder_d   = remainder_q;
        div_by_zero_d = div_by_zero_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        state_d       = DONE;
                        quotient_d    = '0;
                        remainder_d   = '0;
                        div_by_zero_d = 1'b1;
                    end else begin
                        state_d   = RUN;
                        quo_d     = dividend_mag;
                        dsr_d     = divisor_mag;
                        rem_d     = '0;
                        count_d   = '0;
                        quo_neg_d = signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        rem_neg_d = signed_mode & dividend[WIDTH-1];
                    end
                end
            end
            RUN: begin
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shifted[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // MIN / -1 wraps naturally: the magnitude 2^(WIDTH-1) negates
                // to itself, giving quotient MIN with no flag.
                quotient_d    = quo_neg_q ? -quo_q : quo_q;
                remainder_d   = rem_neg_q ? -rem_q : rem_q;
                div_by_zero_d = 1'b0;
                state_d       = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d       = (state_d != IDLE);
        result_rdy_d = (state_d == DONE);
    end

    // Single state register. Reset discards any operation in flight and
    // clears every visible output.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            rem_q         <= '0;
            quo_q         <= '0;
            dsr_q         <= '0;
            count_q       <= '0;
            quo_neg_q     <= 1'b0;
            rem_neg_q     <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            busy_q        <= 1'b0;
            result_rdy_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            quo_q         <= quo_d;
            dsr_q         <= dsr_d;
            count_q       <= count_d;
            quo_neg_q     <= quo_neg_d;
            rem_neg_q     <= rem_neg_d;
            quotient_q    <= quotient_d;
            remainder_q   <= remainder_d;
            div_by_zero_q <= div_by_zero_d;
            busy_q        <= busy_d;
            result_rdy_q  <= result_rdy_d;
        end
    end

    assign busy        = busy_q;
    assign result_rdy  = result_rdy_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule
